conv_read_sequencer: RTL and testbench

Read-side initiator for the 3×3 convolution datapath. It walks a feature map stored in the width×height fmap memory and issues, once per cycle, the nine tap row/column addresses, the per-tap read enables, the channel-slice step and the bias enable. These drive the control part that gates memory data into the PE array. The block replaces the RAM-side stimulus that currently drives readi_wr, readi_hr, en_read, en_bias and stepr.

---
 rtl/conv_seq_pkg.sv | 23 ++
 rtl/tap_addr_gen.sv | 47 ++++
 rtl/conv_read_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_conv_read_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the 3x3 convolution read sequencer.
// Tap k sits at kernel offset (dy, dx) = (k / 3, k % 3).
package conv_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seq_state_e;

    localparam int unsigned MaxSteps = 6;
    localparam int unsigned NumTaps  = 9;

    // Element k holds the offset of tap k; index 0 is the rightmost element.
    localparam logic [8:0][1:0] TapDx = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
    localparam logic [8:0][1:0] TapDy = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};

    // Bit position of tap k in the packed tap buses; tap 0 is the MSB slot.
    function automatic int unsigned tap_bit(int unsigned k);
        return NumTaps - 1 - k;
    endfunction

endpackage

// File: rtl/tap_addr_gen.sv
// One tap's address: (x, y, dx, dy) -> column, row and in-bounds flag.
// With CONV_SEQ_ZERO_PAD_EN defined, out-of-image taps are masked and zeroed.
module tap_addr_gen #(
    parameter int unsigned width_b  = 7,
    parameter int unsigned height_b = 3
) (
    input  logic [width_b-1:0]  x_i,
    input  logic [height_b-1:0] y_i,
    input  logic [1:0]          dx_i,
    input  logic [1:0]          dy_i,
    input  logic [width_b-1:0]  xlim_i,
    input  logic [height_b-1:0] ylim_i,
    output logic [width_b-1:0]  col_o,
    output logic [height_b-1:0] row_o,
    output logic                inb_o
);

    logic signed [width_b:0]  col_s;
    logic signed [height_b:0] row_s;

    assign col_s = $signed({1'b0, x_i}) + $signed((width_b + 1)'(dx_i))
                 - $signed((width_b + 1)'(1));
    assign row_s = $signed({1'b0, y_i}) + $signed((height_b + 1)'(dy_i))
                 - $signed((height_b + 1)'(1));

`ifdef CONV_SEQ_ZERO_PAD_EN
    logic in_col;
    logic in_row;

    always_comb begin
        in_col = !col_s[width_b] && (col_s[width_b-1:0] <= xlim_i);
        in_row = !row_s[height_b] && (row_s[height_b-1:0] <= ylim_i);
        inb_o  = in_col && in_row;
        col_o  = inb_o ? col_s[width_b-1:0] : '0;
        row_o  = inb_o ? row_s[height_b-1:0] : '0;
    end
`else
    // Valid-only walk keeps every tap inside the image, so no bound check.
    logic unused_bits;

    assign unused_bits = ^{col_s[width_b], row_s[height_b], xlim_i, ylim_i};
    assign col_o       = col_s[width_b-1:0];
    assign row_o       = row_s[height_b-1:0];
    assign inb_o       = 1'b1;
`endif

endmodule

// File: rtl/conv_read_sequencer.sv
// Read-side initiator for the 3x3 convolution: walks pixels and slices, issuing nine taps
// per cycle. Macro CONV_SEQ_ZERO_PAD_EN selects same-padding; undefined gives valid-only.
module conv_read_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned width     = 80,
    parameter int unsigned height    = 8,
    parameter int unsigned width_b   = 7,
    parameter int unsigned height_b  = 3,
    parameter int unsigned MAX_STEPS = MaxSteps
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [width_b-1:0]    cfg_w,
    input  logic [height_b-1:0]   cfg_h,
    input  logic [2:0]            cfg_steps,
    input  logic                  stall,
    output logic [width_b*9-1:0]  readi_wr,
    output logic [height_b*9-1:0] readi_hr,
    output logic [8:0]            en_read,
    output logic                  en_bias,
    output logic [2:0]            stepr,
    output logic                  valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    seq_state_e state_q, state_d;

    logic [width_b-1:0]  cfg_w_q, cfg_w_d;
    logic [height_b-1:0] cfg_h_q, cfg_h_d;
    logic [2:0]          cfg_s_q, cfg_s_d;
    logic [width_b-1:0]  x_q, x_d;
    logic [height_b-1:0] y_q, y_d;
    logic [2:0]          s_q, s_d;

    logic [width_b*9-1:0]  wr_q, wr_d;
    logic [height_b*9-1:0] hr_q, hr_d;
    logic [8:0]            en_q, en_d;
    logic                  bias_q, bias_d;
    logic [2:0]            step_q, step_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                go, cfg_ok, issue, last;
    logic [width_b-1:0]  w_eff, x_min, x_max, px;
    logic [height_b-1:0] h_eff, y_min, y_max, py;
    logic [2:0]          s_eff, ps;

    logic [8:0][width_b-1:0]  tap_col;
    logic [8:0][height_b-1:0] tap_row;
    logic [8:0]               tap_inb;

    // On the start edge the first read is issued from the incoming config, so the
    // pending position and limits come straight from the inputs in that cycle.
    always_comb begin
        go     = (state_q == StIdle) && start;
        cfg_ok = (32'(cfg_w) < width) && (32'(cfg_h) < height) && (32'(cfg_steps) < MAX_STEPS);
`ifndef CONV_SEQ_ZERO_PAD_EN
        cfg_ok = cfg_ok && (cfg_w >= width_b'(2)) && (cfg_h >= height_b'(2));
`endif
        w_eff = go ? cfg_w : cfg_w_q;
        h_eff = go ? cfg_h : cfg_h_q;
        s_eff = go ? cfg_steps : cfg_s_q;
`ifdef CONV_SEQ_ZERO_PAD_EN
        x_min = '0;
        x_max = w_eff;
        y_min = '0;
        y_max = h_eff;
`else
        x_min = width_b'(1);
        x_max = w_eff - width_b'(1);
        y_min = height_b'(1);
        y_max = h_eff - height_b'(1);
`endif
        px = go ? x_min : x_q;
        py = go ? y_min : y_q;
        ps = go ? 3'd0 : s_q;
    end

    for (genvar k = 0; k < 9; k++) begin : g_tap
        tap_addr_gen #(
            .width_b  (width_b),
            .height_b (height_b)
        ) u_tap (
            .x_i    (px),
            .y_i    (py),
            .dx_i   (TapDx[k]),
            .dy_i   (TapDy[k]),
            .xlim_i (w_eff),
            .ylim_i (h_eff),
            .col_o  (tap_col[k]),
            .row_o  (tap_row[k]),
            .inb_o  (tap_inb[k])
        );
    end

    always_comb begin
        state_d = state_q;
        cfg_w_d = cfg_w_q;
        cfg_h_d = cfg_h_q;
        cfg_s_d = cfg_s_q;
        x_d     = px;
        y_d     = py;
        s_d     = ps;
        wr_d    = '0;
        hr_d    = '0;
        en_d    = '0;
        bias_d  = 1'b0;
        step_d  = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        issue   = 1'b0;
        last    = (ps == s_eff) && (px == x_max) && (py == y_max);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        cfg_w_d = cfg_w;
                        cfg_h_d = cfg_h;
                        cfg_s_d = cfg_steps;
                        state_d = StRun;
                        issue   = !stall;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                issue = !stall;
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            valid_d = 1'b1;
            bias_d  = (ps == 3'd0);
            step_d  = ps;
            for (int k = 0; k < 9; k++) begin
                wr_d[tap_bit(k)*width_b +: width_b]   = tap_col[k];
                hr_d[tap_bit(k)*height_b +: height_b] = tap_row[k];
                en_d[tap_bit(k)]                      = tap_inb[k];
            end
            if (ps == s_eff) begin
                s_d = '0;
                if (px == x_max) begin
                    x_d = x_min;
                    y_d = py + height_b'(1);
                end else begin
                    x_d = px + width_b'(1);
                end
            end else begin
                s_d = ps + 3'd1;
            end
            if (last) begin
                state_d = StDone;
            end
        end

        busy_d = (state_d != StIdle) || done_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cfg_w_q <= '0;
            cfg_h_q <= '0;
            cfg_s_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            wr_q    <= '0;
            hr_q    <= '0;
            en_q    <= '0;
            bias_q  <= 1'b0;
            step_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_w_q <= cfg_w_d;
            cfg_h_q <= cfg_h_d;
            cfg_s_q <= cfg_s_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            wr_q    <= wr_d;
            hr_q    <= hr_d;
            en_q    <= en_d;
            bias_q  <= bias_d;
            step_q  <= step_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign readi_wr = wr_q;
    assign readi_hr = hr_q;
    assign en_read  = en_q;
    assign en_bias  = bias_q;
    assign stepr    = step_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_conv_read_sequencer.sv
// Scoreboard bench for conv_read_sequencer: expected reads are queued per job and
// popped as valid reads appear. Follows CONV_SEQ_ZERO_PAD_EN like the design.
module tb_conv_read_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stall;
    logic [6:0]  cfg_w;
    logic [2:0]  cfg_h, cfg_steps;
    logic [62:0] readi_wr;
    logic [26:0] readi_hr;
    logic [8:0]  en_read;
    logic        en_bias, valid, busy, done, err;
    logic [2:0]  stepr;

    typedef struct packed {
        logic [62:0] wr;
        logic [26:0] hr;
        logic [8:0]  en;
        logic        bias;
        logic [2:0]  step;
    } rd_t;

    rd_t obs;
    rd_t exp_q[$];
    rd_t first_rd, last_rd;
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    assign obs = {readi_wr, readi_hr, en_read, en_bias, stepr};

    conv_read_sequencer u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_w     (cfg_w),
        .cfg_h     (cfg_h),
        .cfg_steps (cfg_steps),
        .stall     (stall),
        .readi_wr  (readi_wr),
        .readi_hr  (readi_hr),
        .en_read   (en_read),
        .en_bias   (en_bias),
        .stepr     (stepr),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rd_t model_rd(int x, int y, int s, int w, int h);
        rd_t r;
        int  c, rw;
        bit  inb;
        r = '0;
        for (int k = 0; k < 9; k++) begin
            c  = x + (k % 3) - 1;
            rw = y + (k / 3) - 1;
`ifdef CONV_SEQ_ZERO_PAD_EN
            inb = (c >= 0) && (c <= w) && (rw >= 0) && (rw <= h);
`else
            inb = 1'b1;
`endif
            if (inb) begin
                r.wr[(8-k)*7 +: 7] = c[6:0];
                r.hr[(8-k)*3 +: 3] = rw[2:0];
                r.en[8-k]          = 1'b1;
            end
        end
        r.bias = (s == 0);
        r.step = s[2:0];
        return r;
    endfunction

    task automatic push_job(int w, int h, int st);
        int x0, x1, y0, y1;
`ifdef CONV_SEQ_ZERO_PAD_EN
        x0 = 0; x1 = w;     y0 = 0; y1 = h;
`else
        x0 = 1; x1 = w - 1; y0 = 1; y1 = h - 1;
`endif
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                for (int s = 0; s <= st; s++)
                    exp_q.push_back(model_rd(x, y, s, w, h));
    endtask

    // stall_at > 0: after that many reads, stall two cycles and pulse start while busy.
    task automatic run_job(input string tag, input int w, input int h, input int st,
                           input int stall_at, output rd_t f_rd, output rd_t l_rd);
        int   n_exp, cyc, nval, stall_left, stalls, done_cyc;
        logic prev_stall;
        rd_t  e;
        f_rd = '0;
        l_rd = '0;
        exp_q.delete();
        push_job(w, h, st);
        n_exp = exp_q.size();
        @(posedge clk);
        #1;
        cfg_w = 7'(w); cfg_h = 3'(h); cfg_steps = 3'(st); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0; nval = 0; stall_left = 0; stalls = 0; done_cyc = -1; prev_stall = 1'b0;
        while (done_cyc < 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            check_eq({tag, "_valid"}, valid, (!prev_stall && exp_q.size() > 0));
            check_eq({tag, "_busy"}, busy, 1'b1);
            if (valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq({tag, "_read"}, obs, e);
                if (nval == 0) f_rd = obs;
                l_rd = obs;
                nval++;
            end else if (!valid) begin
                check_eq({tag, "_idle_out"}, obs, '0);
            end
            if (done) done_cyc = cyc;
            if (stall_at > 0 && nval == stall_at && stalls == 0) begin
                stall_left = 2;
                stalls     = 2;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            prev_stall = stall;
        end
        stall = 1'b0;
        start = 1'b0;
        check_eq({tag, "_done_cycle"}, done_cyc, n_exp + 1 + stalls);
        check_eq({tag, "_left_in_queue"}, exp_q.size(), 0);
        @(negedge clk);
        check_eq({tag, "_after_flags"}, {busy, done, valid, err}, 4'b0);
    endtask

    task automatic reject(input string tag, input logic [6:0] w, input logic [2:0] h,
                          input logic [2:0] st);
        @(posedge clk);
        #1;
        cfg_w = w; cfg_h = h; cfg_steps = st; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_eq({tag, "_err_busy_valid"}, {err, busy, valid}, 3'b100);
        repeat (3) begin
            @(negedge clk);
            check_eq({tag, "_quiet"}, {err, busy, valid}, 3'b000);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        cfg_w = '0; cfg_h = '0; cfg_steps = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_out", obs, '0);
        check_eq("reset_flags", {valid, busy, done, err}, 4'b0);
        reset = 1'b0;

`ifdef CONV_SEQ_ZERO_PAD_EN
        run_job("walk", 3, 2, 0, 0, first_rd, last_rd);
        check_eq("walk_first_en", first_rd.en, 9'h01B);
        check_eq("walk_first_tap4", {first_rd.wr[4*7 +: 7], first_rd.hr[4*3 +: 3]}, 10'h000);
        check_eq("walk_first_tap8", {first_rd.wr[6:0], first_rd.hr[2:0]}, {7'd1, 3'd1});
        check_eq("walk_last_en", last_rd.en, 9'h1B0);
        check_eq("walk_last_tap4", {last_rd.wr[4*7 +: 7], last_rd.hr[4*3 +: 3]}, {7'd3, 3'd2});
`else
        run_job("walk", 3, 3, 0, 0, first_rd, last_rd);
        check_eq("walk_first_en", first_rd.en, 9'h1FF);
        check_eq("walk_first_tap0", {first_rd.wr[62:56], first_rd.hr[26:24]}, 10'h000);
        check_eq("walk_last_en", last_rd.en, 9'h1FF);
`endif

        run_job("slice", 4, 3, 2, 0, first_rd, last_rd);
        check_eq("slice_first_bias_step", {first_rd.bias, first_rd.step}, 4'b1000);
        check_eq("slice_last_bias_step", {last_rd.bias, last_rd.step}, 4'b0010);

        run_job("stall", 3, 3, 1, 3, first_rd, last_rd);

        reject("rej_w", 7'd80, 3'd3, 3'd0);
        reject("rej_steps", 7'd3, 3'd3, 3'd6);
`ifndef CONV_SEQ_ZERO_PAD_EN
        reject("rej_h", 7'd3, 3'd1, 3'd0);
`endif

        // Asynchronous reset in the middle of a walk, then a clean restart.
        @(posedge clk);
        #1;
        cfg_w = 7'd4; cfg_h = 3'd3; cfg_steps = 3'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrun_reset_out", obs, '0);
        check_eq("midrun_reset_flags", {valid, busy, done, err}, 4'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_job("restart", 4, 3, 1, 0, first_rd, last_rd);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
